// File: rtl/sync_fifo_prog.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo_prog
//  Description : Single-clock FIFO with programmable almost-full and
//                almost-empty levels, overflow/underflow pulses, Gray-coded
//                pointer outputs and a selectable read mode (registered read
//                or first-word-fall-through).
//
//  Ports
//    clk          : sole clock, all logic on the rising edge
//    rst          : synchronous active-high reset
//    w_en/w_data  : write request and write word
//    r_en         : read request (pop)
//    r_data       : read word
//    r_valid      : r_data holds a valid word
//    full/empty   : count == DEPTH / count == 0
//    almost_full  : count >= af_thresh (forced low when af_thresh == 0)
//    almost_empty : count <= ae_thresh
//    af_thresh    : programmable almost-full level, sampled every cycle
//    ae_thresh    : programmable almost-empty level, sampled every cycle
//    count        : stored words, 0..DEPTH
//    overflow     : one-cycle pulse after a rejected write
//    underflow    : one-cycle pulse after a rejected read
//    w_ptr/r_ptr  : Gray-coded write / read pointers
//
//  Revision    : 1.0  initial release
// ============================================================================
module sync_fifo_prog #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDRESS_SIZE = 4,
    parameter int FWFT         = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    w_en,
    input  logic [DATA_WIDTH-1:0]   w_data,
    input  logic                    r_en,
    output logic [DATA_WIDTH-1:0]   r_data,
    output logic                    r_valid,
    output logic                    full,
    output logic                    empty,
    output logic                    almost_full,
    output logic                    almost_empty,
    input  logic [ADDRESS_SIZE:0]   af_thresh,
    input  logic [ADDRESS_SIZE:0]   ae_thresh,
    output logic [ADDRESS_SIZE:0]   count,
    output logic                    overflow,
    output logic                    underflow,
    output logic [ADDRESS_SIZE:0]   w_ptr,
    output logic [ADDRESS_SIZE:0]   r_ptr
);

    localparam int                  c_DEPTH     = 1 << ADDRESS_SIZE;
    localparam logic [ADDRESS_SIZE:0] c_DEPTH_CNT = c_DEPTH[ADDRESS_SIZE:0];
    localparam logic [ADDRESS_SIZE:0] c_ONE       = {{ADDRESS_SIZE{1'b0}}, 1'b1};
    localparam logic [ADDRESS_SIZE:0] c_ZERO      = '0;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0]  r_mem [c_DEPTH];

    logic [ADDRESS_SIZE:0]  r_wbin;
    logic [ADDRESS_SIZE:0]  r_rbin;
    logic [ADDRESS_SIZE:0]  r_wgray;
    logic [ADDRESS_SIZE:0]  r_rgray;
    logic [ADDRESS_SIZE:0]  r_count;
    logic                   r_full;
    logic                   r_empty;
    logic                   r_af;
    logic                   r_ae;
    logic                   r_ovf;
    logic                   r_unf;
    logic [DATA_WIDTH-1:0]  r_rdata;
    logic                   r_rvalid;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    logic                   w_wr_acc;
    logic                   w_rd_acc;
    logic [ADDRESS_SIZE:0]  w_wbin_nxt;
    logic [ADDRESS_SIZE:0]  w_rbin_nxt;
    logic [ADDRESS_SIZE:0]  w_count_nxt;

    always_comb begin
        // A read needs a stored word; a same-cycle write cannot rescue it.
        w_rd_acc = r_en && !r_empty;
        // A full FIFO still takes a write when a read frees a slot this cycle.
        w_wr_acc = w_en && (!r_full || w_rd_acc);

        w_wbin_nxt = w_wr_acc ? (r_wbin + c_ONE) : r_wbin;
        w_rbin_nxt = w_rd_acc ? (r_rbin + c_ONE) : r_rbin;

        case ({w_wr_acc, w_rd_acc})
            2'b10:   w_count_nxt = r_count + c_ONE;
            2'b01:   w_count_nxt = r_count - c_ONE;
            default: w_count_nxt = r_count;
        endcase
    end

    // ------------------------------------------------------------------
    // Pointers, count and flags. Flags are derived from the next count so
    // they line up with the registered count without an extra cycle of lag.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wbin  <= '0;
            r_rbin  <= '0;
            r_wgray <= '0;
            r_rgray <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
            r_af    <= 1'b0;
            r_ae    <= 1'b1;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_wbin  <= w_wbin_nxt;
            r_rbin  <= w_rbin_nxt;
            r_wgray <= w_wbin_nxt ^ (w_wbin_nxt >> 1);
            r_rgray <= w_rbin_nxt ^ (w_rbin_nxt >> 1);
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == c_DEPTH_CNT);
            r_empty <= (w_count_nxt == c_ZERO);
            r_af    <= (af_thresh != c_ZERO) && (w_count_nxt >= af_thresh);
            r_ae    <= (w_count_nxt <= ae_thresh);
            r_ovf   <= w_en && !w_wr_acc;
            r_unf   <= r_en && !w_rd_acc;
        end
    end

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wbin[ADDRESS_SIZE-1:0]] <= w_data;
        end
    end

    // ------------------------------------------------------------------
    // Read port
    // ------------------------------------------------------------------
    generate
        if (FWFT != 0) begin : g_fwft
            logic [ADDRESS_SIZE-1:0] w_head_addr;
            logic                    w_bypass;

            // The word being written this cycle becomes the head only when it
            // lands at the next read address, i.e. the FIFO holds just that
            // word afterwards; it is not in storage yet, so forward it.
            assign w_head_addr = w_rbin_nxt[ADDRESS_SIZE-1:0];
            assign w_bypass    = w_wr_acc && (r_wbin[ADDRESS_SIZE-1:0] == w_head_addr);

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_rdata  <= '0;
                    r_rvalid <= 1'b0;
                end else begin
                    r_rvalid <= (w_count_nxt != c_ZERO);
                    if (w_count_nxt != c_ZERO) begin
                        r_rdata <= w_bypass ? w_data : r_mem[w_head_addr];
                    end
                end
            end
        end else begin : g_std
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_rdata  <= '0;
                    r_rvalid <= 1'b0;
                end else if (w_rd_acc) begin
                    r_rdata  <= r_mem[r_rbin[ADDRESS_SIZE-1:0]];
                    r_rvalid <= 1'b1;
                end else begin
                    r_rvalid <= 1'b0;
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign r_data       = r_rdata;
    assign r_valid      = r_rvalid;
    assign full         = r_full;
    assign empty        = r_empty;
    assign almost_full  = r_af;
    assign almost_empty = r_ae;
    assign count        = r_count;
    assign overflow     = r_ovf;
    assign underflow    = r_unf;
    assign w_ptr        = r_wgray;
    assign r_ptr        = r_rgray;

endmodule
`default_nettype wire

// File: doc/sync_fifo_prog.md
SYNC_FIFO_PROG -- requirements
Module: sync_fifo_prog

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, meaning width of each stored word.
REQ-002 The block SHALL have parameter ADDRESS_SIZE, default 4, meaning log2 of depth; DEPTH = 2**ADDRESS_SIZE.
REQ-003 The block SHALL have parameter FWFT, default 0, meaning read mode: 0 = registered read, 1 = first-word-fall-through.
REQ-004 Ports SHALL be:
- clk  in  1  sole clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- w_en  in  1  write request.
- w_data  in  DATA_WIDTH  write word.
- r_en  in  1  read request (pop).
- r_data  out  DATA_WIDTH  read word.
- r_valid  out  1  r_data holds a valid word.
- full  out  1  count == DEPTH.
- empty  out  1  no word readable.
- almost_full  out  1  count >= af_thresh.
- almost_empty  out  1  count <= ae_thresh.
- af_thresh  in  ADDRESS_SIZE+1  programmable almost-full level.
- ae_thresh  in  ADDRESS_SIZE+1  programmable almost-empty level.
- count  out  ADDRESS_SIZE+1  stored words, 0..DEPTH.
- overflow  out  1  one-cycle pulse: write rejected.
- underflow  out  1  one-cycle pulse: read rejected.
- w_ptr  out  ADDRESS_SIZE+1  Gray-coded write pointer.
- r_ptr  out  ADDRESS_SIZE+1  Gray-coded read pointer.

Function
REQ-005 Storage SHALL be DEPTH words; internal binary pointers SHALL be ADDRESS_SIZE+1 bits, with the low ADDRESS_SIZE bits addressing storage, wrapping modulo 2*DEPTH.
REQ-006 Writes SHALL be accepted when w_en=1 and (full=0, or a read is accepted in the same cycle).
REQ-007 Reads SHALL be accepted when r_en=1 and empty=0; a read is never accepted in a cycle where empty=1, even if a write is accepted in that cycle.
REQ-008 count SHALL change by +1 on write-only, -1 on read-only, and 0 on simultaneous accepted write and read.
REQ-009 full, empty, almost_full, almost_empty SHALL be registered and consistent with the registered count in the same cycle, with no extra lag.
REQ-010 almost_full SHALL be forced to 0 when af_thresh == 0; threshold inputs SHALL be sampled every cycle.
REQ-011 A write with w_en=1 that is not accepted SHALL pulse overflow for exactly one cycle, in the cycle after the attempt; state SHALL be unchanged.
REQ-012 A read with r_en=1 that is not accepted SHALL pulse underflow for exactly one cycle, in the cycle after the attempt; state SHALL be unchanged.
REQ-013 In FWFT=0 mode:
- an accepted read SHALL present the head word on r_data with r_valid=1 in the following cycle;
- r_valid=0 otherwise, and r_data SHALL hold its last value.
REQ-014 In FWFT=1 mode:
- r_data SHALL show the head word and r_valid SHALL equal !empty;
- an accepted read SHALL advance to the next word in the following cycle;
- a word written into an empty FIFO SHALL appear with r_valid=1 one cycle after the write edge.
REQ-015 w_ptr and r_ptr SHALL be the registered binary-to-Gray conversion of the binary pointers; exactly one bit changes per increment, including the wrap from 2*DEPTH-1 to 0.

Reset
REQ-016 While rst=1 at a clk edge, the following SHALL be cleared: pointers, count=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0, r_valid=0, r_data=0, w_ptr=0, r_ptr=0.
REQ-017 Reset SHALL take priority over simultaneous w_en/r_en; storage contents need not be cleared.
REQ-018 Reset asserted mid-operation SHALL discard all stored words; the first post-reset write SHALL be read first.

Verification (DATA_WIDTH=8, ADDRESS_SIZE=2, DEPTH=4)
REQ-019 Reset with w_en=r_en=1 held -> empty=1, count=0, overflow=0, underflow=0 throughout reset.
REQ-020 Write 0x11,0x22,0x33,0x44, then a 5th write 0x55 -> full=1, count=4, overflow pulses 1 cycle, and later reads return 0x11..0x44 (0x55 absent).
REQ-021 When full, simultaneous write 0xAA and read -> count stays 4, full stays 1, no overflow; 0xAA is read out last.
REQ-022 On empty, r_en=1 with w_en=1 (0x5A) -> underflow pulses, count=1; in FWFT=1 r_data=0x5A with r_valid=1 the next cycle.
REQ-023 ae_thresh=1, af_thresh=3; fill 0->4 then drain -> almost_empty=1 at count 0,1; almost_full=1 at count 3,4; af_thresh=0 -> almost_full=0.
REQ-024 Run 10 write/read cycles -> pointers wrap, w_ptr/r_ptr change exactly one bit per increment, and data order is preserved.
